sr_drive_sequencer: RTL and testbench

- Upstream command stage for the gated NOR SR flip-flop.
- Converts single-cycle set/clear requests into clean, width-controlled s/r drive pulses, with a guaranteed idle gap between them.
- Never asserts s and r together, and skips commands that would not change the latch.
- Tracks the expected latch state and forces a known latch state after reset.

---
 rtl/sr_drive_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sr_drive_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_sequencer.sv
// Purpose: turns single-cycle set/clear requests into width-controlled s/r drive
//          pulses for a gated NOR SR latch, with an idle gap between pulses.
// Latency: request sampled at edge N is dispatched at edge N+1 when IDLE; no backpressure,
//          so a request that cannot be taken overwrites the single pending slot and bumps drop_cnt.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   set_req   request to set the latch (sampled every edge)
//   clr_req   request to clear the latch (sampled every edge, wins over set_req)
//   s, r      registered latch drives, never high together
//   q_exp     expected latch state after the last completed command
//   busy      high whenever the sequencer is not IDLE
//   done      one-cycle pulse when a command, a skipped command or the init completes
//   drop_cnt  saturating count of conflicting or overwritten requests
module sr_drive_sequencer #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       q_exp,
  output logic       busy,
  output logic       done,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRIVE_S,
    ST_DRIVE_R,
    ST_GAP
  } state_t;

  // Drive states count 1..PULSE_W (the dispatch edge loads 1), so the counter
  // reaching PULSE_W marks the last drive cycle. INIT starts from 0 because
  // its first cycle (the reset cycle) has r low.
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s_nxt, r_nxt, done_nxt, q_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             pend_clr, pend_clr_nxt;
  logic [7:0]       drop_nxt;
  logic             consume;
  logic             req;
  logic             drop_evt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      q_exp    <= 1'b0;
      pend_vld <= 1'b0;
      pend_clr <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      s        <= s_nxt;
      r        <= r_nxt;
      done     <= done_nxt;
      q_exp    <= q_nxt;
      pend_vld <= pend_vld_nxt;
      pend_clr <= pend_clr_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_nxt     = s;
    r_nxt     = r;
    done_nxt  = 1'b0;
    q_nxt     = q_exp;
    consume   = 1'b0;

    case (state)
      ST_INIT: begin
        q_nxt = 1'b0;
        s_nxt = 1'b0;
        if (cnt != PULSE_END) begin
          r_nxt   = 1'b1;
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          r_nxt   = 1'b0;
          cnt_nxt = '0;
          if (GAP_W == 0) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_GAP;
          end
        end
      end

      ST_IDLE: begin
        s_nxt = 1'b0;
        r_nxt = 1'b0;
        if (pend_vld) begin
          consume = 1'b1;
          // A CLR pending while q_exp=0 (or SET while q_exp=1) leaves the
          // latch unchanged: acknowledge it without driving anything.
          if (pend_clr != q_exp) begin
            done_nxt = 1'b1;
          end else if (pend_clr) begin
            state_nxt = ST_DRIVE_R;
            r_nxt     = 1'b1;
            cnt_nxt   = CNT_ONE;
          end else begin
            state_nxt = ST_DRIVE_S;
            s_nxt     = 1'b1;
            cnt_nxt   = CNT_ONE;
          end
        end
      end

      ST_DRIVE_S, ST_DRIVE_R: begin
        if (cnt != PULSE_END) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          s_nxt   = 1'b0;
          r_nxt   = 1'b0;
          q_nxt   = (state == ST_DRIVE_S);
          cnt_nxt = '0;
          if (GAP_W == 0) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        s_nxt = 1'b0;
        r_nxt = 1'b0;
        if (cnt != GAP_LAST) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        // Unused encodings fall back to a fresh init sequence.
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
      end
    endcase
  end

  // Single-entry pending slot. A same-edge set+clear and an overwrite of an
  // untaken entry on the same edge are counted as one drop.
  always_comb begin
    req      = set_req | clr_req;
    drop_evt = req & ((set_req & clr_req) | (pend_vld & ~consume));

    pend_vld_nxt = pend_vld;
    pend_clr_nxt = pend_clr;
    if (req) begin
      pend_vld_nxt = 1'b1;
      pend_clr_nxt = clr_req;
    end else if (consume) begin
      pend_vld_nxt = 1'b0;
    end

    drop_nxt = drop_cnt;
    if (drop_evt && (drop_cnt != 8'hFF)) begin
      drop_nxt = drop_cnt + 8'd1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sr_drive_sequencer.sv
module tb_sr_drive_sequencer;

  localparam int PULSE_W = 4;
  localparam int GAP_W   = 2;
  localparam int BIG     = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_req = 1'b0;
  logic       clr_req = 1'b0;
  logic       s, r, q_exp, busy, done;
  logic [7:0] drop_cnt;

  sr_drive_sequencer #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .q_exp(q_exp), .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = skipped (no pulse), 1 = s pulse, 2 = r pulse
  typedef struct { int kind; int done_edge; int q; } txn_t;
  typedef struct { int s; int r; int busy; int done; int q; int drop; } stat_t;

  txn_t  txq[$];
  stat_t stq[$];

  int checks = 0;
  int errors = 0;
  int mon_edge = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", name, mon_edge, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: one command in flight, described by its start edge,
  // kind and completion edge; the sequencer can accept again at free_at.
  int t = 0;
  int m_q = 0, m_pv = 0, m_pc = 0, m_drop = 0;
  int m_init = 0;
  int m_free = BIG;
  int m_kind = 0, m_start = -BIG;
  int m_done = -1;
  int m_qedge = BIG, m_qval = 0;

  task automatic model_step(input bit rs, input bit st, input bit cl);
    stat_t x;
    txn_t  tx;
    int    done_now;
    int    consumed;
    int    want;
    if (!rs) begin
      m_q = 0; m_pv = 0; m_pc = 0; m_drop = 0; m_init = 1;
      m_free = BIG; m_kind = 0; m_done = -1; m_qedge = BIG;
      txq.delete();
      x = '{0, 0, 1, 0, 0, 0};
      stq.push_back(x);
      return;
    end
    if (m_qedge <= t) begin
      m_q = m_qval;
      m_qedge = BIG;
    end
    done_now = (t == m_done);
    consumed = 0;
    if (m_init) begin
      m_init = 0;
      m_kind = 2; m_start = t;
      m_qedge = t + PULSE_W; m_qval = 0;
      m_done = t + PULSE_W + GAP_W; m_free = m_done + 1;
      tx = '{2, m_done, 0};
      txq.push_back(tx);
    end else if (t >= m_free && m_pv) begin
      consumed = 1;
      want = m_pc ? 0 : 1;
      if (want == m_q) begin
        done_now = 1;
        m_free = t + 1;
        tx = '{0, t, m_q};
        txq.push_back(tx);
      end else begin
        m_kind = want ? 1 : 2; m_start = t;
        m_qedge = t + PULSE_W; m_qval = want;
        m_done = t + PULSE_W + GAP_W; m_free = m_done + 1;
        tx = '{m_kind, m_done, want};
        txq.push_back(tx);
      end
    end
    if (st || cl) begin
      if ((st && cl) || (m_pv && !consumed)) begin
        if (m_drop < 255) m_drop++;
      end
      m_pv = 1;
      m_pc = cl;
    end else if (consumed) begin
      m_pv = 0;
    end
    x.s    = (m_kind == 1 && t >= m_start && t < m_start + PULSE_W) ? 1 : 0;
    x.r    = (m_kind == 2 && t >= m_start && t < m_start + PULSE_W) ? 1 : 0;
    x.busy = (t < m_free - 1) ? 1 : 0;
    x.done = done_now;
    x.q    = m_q;
    x.drop = m_drop;
    stq.push_back(x);
  endtask

  // Apply inputs, let the DUT sample them, advance the model by the same edge.
  task automatic step(input bit rs, input bit st, input bit cl);
    rst = rs; set_req = st; clr_req = cl;
    @(posedge clk);
    t++;
    model_step(rs, st, cl);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  bit    mon_rst;
  int    s_w = 0, r_w = 0, last_kind = 0, last_w = 0;
  stat_t ex;
  txn_t  et;

  initial begin
    forever begin
      @(posedge clk);
      mon_edge++;
      mon_rst = rst;
      @(negedge clk);
      if (stq.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_queue_empty edge=%0d got=empty want=entry", mon_edge);
      end else begin
        ex = stq.pop_front();
        chk("s", int'(s), ex.s);
        chk("r", int'(r), ex.r);
        chk("busy", int'(busy), ex.busy);
        chk("done", int'(done), ex.done);
        chk("q_exp", int'(q_exp), ex.q);
        chk("drop_cnt", int'(drop_cnt), ex.drop);
      end
      chk("s_and_r", int'(s & r), 0);

      if (!mon_rst) begin
        s_w = 0; r_w = 0; last_kind = 0; last_w = 0;
      end else begin
        if (s) s_w++;
        else if (s_w > 0) begin last_kind = 1; last_w = s_w; s_w = 0; end
        if (r) r_w++;
        else if (r_w > 0) begin last_kind = 2; last_w = r_w; r_w = 0; end
      end

      if (mon_rst && done) begin
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected edge=%0d got=done want=no_done", mon_edge);
        end else begin
          et = txq.pop_front();
          chk("done_edge", mon_edge, et.done_edge);
          chk("pulse_kind", last_kind, et.kind);
          if (et.kind != 0) chk("pulse_width", last_w, PULSE_W);
          chk("txn_q_exp", int'(q_exp), et.q);
        end
        last_kind = 0; last_w = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset and init
    repeat (3) step(1'b0, 1'b0, 1'b0);
    idle(12);
    // set from cleared
    step(1'b1, 1'b1, 1'b0);
    idle(10);
    // redundant set
    step(1'b1, 1'b1, 1'b0);
    idle(4);
    // conflict: clear wins
    step(1'b1, 1'b1, 1'b1);
    idle(10);
    // overwrite during DRIVE_S
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(12);
    // clear, then reset in the middle of a set pulse with a request pending
    step(1'b1, 1'b0, 1'b1);
    idle(10);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    idle(12);
    // heavy random traffic, enough overwrites to saturate drop_cnt
    for (int i = 0; i < 700; i++)
      step(1'b1, ($urandom % 10) < 4, ($urandom % 10) < 4);
    idle(15);
    // sparse random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      step(($urandom % 50) != 0, ($urandom % 8) == 0, ($urandom % 8) == 0);
    idle(20);

    @(negedge clk);
    #1;
    chk("status_queue_left", stq.size(), 0);
    chk("txn_queue_left", txq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
